m_bpred_btb: RTL
================

# m_bpred_btb

Parametrised branch target buffer with fully-associative lookup, true-LRU replacement and CW-bit saturating direction counters. It is the drop-in successor for the processor's 4-entry predictor: the IF stage queries it combinationally with the fetch PC, and the EX stage trains it with resolved branch outcomes. Compared with the 4-entry predictor it adds explicit valid bits, a flush, target rewrite on taken hits, and update/allocation statistics.

## Interface
- ENTRIES, 4, number of BTB entries; power of two, >= 2
- AW, 11, instruction-word address width
- CW, 2, direction counter width; >= 2
- w_clk  in  1  clock; all state updates on posedge
- w_rst_n  in  1  asynchronous active-low reset
- w_flush  in  1  synchronous invalidate-all
- w_be  in  1  update strobe: a resolved branch is presented this cycle
- w_baddr  in  AW  PC of the resolved branch
- w_br  in  1  resolved direction (1 = taken)
- w_bdst  in  AW  resolved taken target
- w_paddr  in  AW  fetch PC to look up
- w_pre  out  1  lookup hit
- w_pr  out  1  predicted taken (MSB of counter); 0 on miss
- w_pdst  out  AW  predicted target; 0 on miss
- w_nupd  out  32  count of accepted updates, saturating
- w_nalloc  out  32  count of allocations (update misses), saturating

## Operation
- Per-entry state: valid, tag[AW], dst[AW], ctr[CW], age[log2 ENTRIES].
- Ages always form a permutation of 0..ENTRIES-1; 0 = MRU, ENTRIES-1 = LRU.
- Reset: valid=0, tag=0, dst=0, ctr=0, age[i]=i, w_nupd=w_nalloc=0. Outputs w_pre=0, w_pr=0, w_pdst=0.
- Lookup (combinational):
  - hit = a valid entry with tag == w_paddr; lowest matching index wins. Duplicates cannot arise, since allocation happens only on a miss.
  - Lookup does not touch ages.
- Update when w_be=1 and w_flush=0:
  - Hit at entry h:
    - w_br=1: ctr saturating +1, dst <= w_bdst.
    - w_br=0: ctr saturating -1, dst unchanged.
  - Miss:
    - Victim is the lowest-index invalid entry; if all entries are valid, the entry with age ENTRIES-1.
    - Victim gets valid=1, tag=w_baddr, dst=w_bdst.
    - ctr = 2^(CW-1) if w_br=1 (weak taken), else 2^(CW-1)-1 (weak not-taken).
    - w_nalloc +1.
  - Touched entry t (h or victim): every age < age[t] increments, age[t] <= 0, all other ages unchanged.
  - w_nupd +1.
- Flush (w_flush=1):
  - valid=0 and age[i]=i for all entries; tags, dst and ctr are don't-care.
  - Statistics are kept.
  - A simultaneous w_be is dropped and is not counted.
- Statistics saturate at 32'hFFFFFFFF and clear only on reset.

## Timing
- Lookup is purely combinational from w_paddr and the registered state. w_paddr -> w_pre/w_pr/w_pdst is valid in the same cycle.
- An update presented in cycle n is visible to lookups in cycle n+1.
- Same-cycle w_be and lookup of the same address: the lookup returns the pre-update state (no bypass).
- w_rst_n low forces the reset state immediately, regardless of clock; all strobes are ignored while it is low.
- The first posedge with w_rst_n high is a normal operating edge.
- Reset asserted mid-sequence discards all entries and statistics.
- No backpressure: every cycle with w_be=1 is consumed. The caller gates w_be during interlock and squash.

## Test plan
- **Reset and empty lookup.** Release reset, w_paddr=0x010 -> w_pre=0, w_pr=0, w_pdst=0, w_nupd=0. Then update baddr=0x010, br=1, bdst=0x004 -> next cycle w_pre=1, w_pr=1, w_pdst=0x004, w_nalloc=1.
- **Counter saturation, CW=2.**
  - Allocate 0x020 with br=0 -> ctr=01, w_pr=0.
  - Two taken updates -> ctr 10 then 11, w_pr=1.
  - Third taken -> ctr stays 11.
  - Three not-taken -> 10, 01, 00; w_pr=0 after the second.
- **LRU eviction, ENTRIES=4.**
  - Allocate A=0x100, B=0x101, C=0x102, D=0x103, then re-update A.
  - Allocating E=0x104 evicts B: lookup B -> w_pre=0; A, C, D, E hit.
  - w_nalloc=5, w_nupd=6.
- **Target rewrite.** Hit 0x030 (dst 0x040) with br=1, bdst=0x050 -> w_pdst=0x050. Then br=0, bdst=0x060 -> w_pdst stays 0x050.
- **Same-cycle update and lookup.** w_paddr=w_baddr=0x070 on a miss -> w_pre=0 that cycle, w_pre=1 the next.
- **Flush and async reset.**
  - w_flush with w_be in the same cycle -> all lookups miss and the counters are unchanged.
  - Pulse w_rst_n low between clock edges -> outputs and statistics go to 0 before the next posedge.

Source files
------------

// File: rtl/m_bpred_btb.sv
// Fully-associative branch target buffer with true-LRU replacement and
// saturating direction counters; combinational lookup, registered training.
module m_bpred_btb #(
  parameter int ENTRIES = 4,
  parameter int AW      = 11,
  parameter int CW      = 2
) (
  input  logic          w_clk,
  input  logic          w_rst_n,
  input  logic          w_flush,
  input  logic          w_be,
  input  logic [AW-1:0] w_baddr,
  input  logic          w_br,
  input  logic [AW-1:0] w_bdst,
  input  logic [AW-1:0] w_paddr,
  output logic          w_pre,
  output logic          w_pr,
  output logic [AW-1:0] w_pdst,
  output logic [31:0]   w_nupd,
  output logic [31:0]   w_nalloc
);

  localparam int IW = $clog2(ENTRIES);
  localparam logic [CW-1:0] CTR_WT  = {1'b1, {(CW-1){1'b0}}};
  localparam logic [CW-1:0] CTR_WNT = {1'b0, {(CW-1){1'b1}}};
  localparam logic [CW-1:0] CTR_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CTR_MIN = {CW{1'b0}};
  localparam logic [IW-1:0] AGE_LRU = IW'(ENTRIES - 1);
  localparam logic [31:0]   STAT_MAX = 32'hFFFF_FFFF;

  logic [ENTRIES-1:0] r_valid;
  logic [AW-1:0]      r_tag [ENTRIES];
  logic [AW-1:0]      r_dst [ENTRIES];
  logic [CW-1:0]      r_ctr [ENTRIES];
  logic [IW-1:0]      r_age [ENTRIES];
  logic [31:0]        r_nupd;
  logic [31:0]        r_nalloc;

  logic          w_phit;
  logic [IW-1:0] w_pidx;
  logic          w_uhit;
  logic [IW-1:0] w_uidx;
  logic          w_has_inv;
  logic [IW-1:0] w_inv_idx;
  logic [IW-1:0] w_lru_idx;
  logic [IW-1:0] w_t;
  logic          w_upd;

  // Match search for fetch and update addresses plus victim selection.
  // Scanning downwards lets the lowest matching index take priority.
  always_comb begin
    w_phit    = 1'b0;
    w_pidx    = '0;
    w_uhit    = 1'b0;
    w_uidx    = '0;
    w_has_inv = 1'b0;
    w_inv_idx = '0;
    w_lru_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_tag[i] == w_paddr)) begin
        w_phit = 1'b1;
        w_pidx = IW'(i);
      end else begin
        w_pidx = w_pidx;
      end
      if (r_valid[i] && (r_tag[i] == w_baddr)) begin
        w_uhit = 1'b1;
        w_uidx = IW'(i);
      end else begin
        w_uidx = w_uidx;
      end
      if (!r_valid[i]) begin
        w_has_inv = 1'b1;
        w_inv_idx = IW'(i);
      end else begin
        w_inv_idx = w_inv_idx;
      end
      if (r_age[i] == AGE_LRU) begin
        w_lru_idx = IW'(i);
      end else begin
        w_lru_idx = w_lru_idx;
      end
    end
    if (w_uhit) begin
      w_t = w_uidx;
    end else if (w_has_inv) begin
      w_t = w_inv_idx;
    end else begin
      w_t = w_lru_idx;
    end
    w_upd = w_be & ~w_flush;
  end

  // Prediction outputs are forced to zero on a miss.
  always_comb begin
    if (w_phit) begin
      w_pre  = 1'b1;
      w_pr   = r_ctr[w_pidx][CW-1];
      w_pdst = r_dst[w_pidx];
    end else begin
      w_pre  = 1'b0;
      w_pr   = 1'b0;
      w_pdst = '0;
    end
  end

  // Entry state, LRU ages and statistics.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_dst[i]   <= '0;
        r_ctr[i]   <= '0;
        r_age[i]   <= IW'(i);
      end
      r_nupd   <= 32'd0;
      r_nalloc <= 32'd0;
    end else if (w_flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_age[i]   <= IW'(i);
      end
    end else if (w_upd) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (IW'(i) == w_t) begin
          r_age[i] <= '0;
        end else if (r_age[i] < r_age[w_t]) begin
          r_age[i] <= r_age[i] + IW'(1);
        end
      end
      if (w_uhit) begin
        if (w_br) begin
          r_dst[w_t] <= w_bdst;
          if (r_ctr[w_t] != CTR_MAX) begin
            r_ctr[w_t] <= r_ctr[w_t] + CW'(1);
          end
        end else if (r_ctr[w_t] != CTR_MIN) begin
          r_ctr[w_t] <= r_ctr[w_t] - CW'(1);
        end
      end else begin
        r_valid[w_t] <= 1'b1;
        r_tag[w_t]   <= w_baddr;
        r_dst[w_t]   <= w_bdst;
        r_ctr[w_t]   <= w_br ? CTR_WT : CTR_WNT;
        if (r_nalloc != STAT_MAX) begin
          r_nalloc <= r_nalloc + 32'd1;
        end
      end
      if (r_nupd != STAT_MAX) begin
        r_nupd <= r_nupd + 32'd1;
      end
    end
  end

  assign w_nupd   = r_nupd;
  assign w_nalloc = r_nalloc;

endmodule
